// File: rtl/fft_twiddle_sched_pkg.sv
// fft_twiddle_sched_pkg: shared types, constants and complex helpers for the twiddle scheduler.
package fft_twiddle_sched_pkg;
  localparam int CW = 12;
  localparam int MUL_LAT = 2;
  localparam logic signed [CW-1:0] W_ONE = 12'sd1024;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  typedef struct packed {
    logic valid;
    logic last;
  } vp_t;
  function automatic logic signed [CW-1:0] cplx_re(input logic [2*CW-1:0] x);
    return x[2*CW-1:CW];
  endfunction
  function automatic logic signed [CW-1:0] cplx_im(input logic [2*CW-1:0] x);
    return x[CW-1:0];
  endfunction
  function automatic logic [2*CW-1:0] cplx_pack(input logic signed [CW-1:0] re, input logic signed [CW-1:0] im);
    return {re, im};
  endfunction
  // The most negative value has no positive twin, so it clips to the largest positive one.
  function automatic logic signed [CW-1:0] sat_neg(input logic signed [CW-1:0] x);
    return (x == {1'b1, {(CW-1){1'b0}}}) ? {1'b0, {(CW-1){1'b1}}} : -x;
  endfunction
endpackage

// File: rtl/fft_twiddle_sched_twiddle_addr_gen.sv
// twiddle_addr_gen: per-frame sample counter and DIF twiddle index / ROM strobe mapping.
module twiddle_addr_gen #(
  parameter int LOG2N = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             accept,
  output logic             last,
  output logic             tw_rd_en,
  output logic [LOG2N-2:0] tw_addr
);
  localparam logic [LOG2N-1:0] N_MAX = '1;
  logic [LOG2N-1:0] n;
  assign last = accept && n == N_MAX;
  assign tw_rd_en = accept;
  // First half of the frame uses W^0; second half walks k = n - N/2.
  assign tw_addr = (accept && n[LOG2N-1]) ? n[LOG2N-2:0] : '0;
  always_ff @(posedge clk)
    if (!reset || clear) n <= '0;
    else if (accept && !last) n <= n + 1'b1;
endmodule

// File: rtl/fft_twiddle_sched.sv
// fft_twiddle_sched: frame sequencer feeding a 2-cycle complex twiddle multiplier.
module fft_twiddle_sched #(
  parameter int LOG2N = 6,
  parameter int DW    = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             inv,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  output logic             in_ready,
  output logic             tw_rd_en,
  output logic [LOG2N-2:0] tw_addr,
  input  logic [DW-1:0]    tw_data,
  output logic [DW-1:0]    mul_c,
  output logic [DW-1:0]    mul_t,
  input  logic [DW-1:0]    mul_out,
  output logic             out_valid,
  output logic [DW-1:0]    out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done
);
  import fft_twiddle_sched_pkg::*;
  state_t state;
  logic inv_q, accept, last;
  vp_t [MUL_LAT:0] vp;
  assign accept = in_valid && in_ready;
  twiddle_addr_gen #(.LOG2N(LOG2N)) u_addr (
    .clk(clk),
    .reset(reset),
    .clear(state == IDLE && start),
    .accept(accept),
    .last(last),
    .tw_rd_en(tw_rd_en),
    .tw_addr(tw_addr)
  );
  assign out_valid = vp[MUL_LAT].valid;
  assign out_last = vp[MUL_LAT].valid && vp[MUL_LAT].last;
  assign out_data = mul_out;
  // ROM data lands one cycle after the read, lining up with the registered sample.
  assign mul_t = vp[0].valid ? (inv_q ? cplx_pack(cplx_re(tw_data), sat_neg(cplx_im(tw_data))) : tw_data) : '0;
  always_ff @(posedge clk)
    if (!reset) begin
      vp <= '0;
      mul_c <= '0;
    end else begin
      vp <= {vp[MUL_LAT-1:0], vp_t'{valid: accept, last: last}};
      mul_c <= accept ? in_data : '0;
    end
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      inv_q <= 1'b0;
      in_ready <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          inv_q <= inv;
          in_ready <= 1'b1;
          busy <= 1'b1;
        end
        RUN: if (last) begin
          state <= DRAIN;
          in_ready <= 1'b0;
        end
        DRAIN: if (out_last) begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fft_twiddle_sched.sv
// tb_fft_twiddle_sched: directed frames against a ROM + 2-cycle multiplier model with a scoreboard.
module tb_fft_twiddle_sched;
  import fft_twiddle_sched_pkg::*;
  localparam int N = 64;
  logic clk = 0, reset = 0, start = 0, inv = 0, in_valid = 0;
  logic [23:0] in_data = 0;
  logic in_ready, tw_rd_en, out_valid, out_last, busy, done;
  logic [4:0] tw_addr;
  logic [23:0] tw_data, mul_c, mul_t, mul_out, out_data;
  always #5 clk = ~clk;
  fft_twiddle_sched dut (
    .clk(clk), .reset(reset), .start(start), .inv(inv), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .tw_rd_en(tw_rd_en), .tw_addr(tw_addr), .tw_data(tw_data),
    .mul_c(mul_c), .mul_t(mul_t), .mul_out(mul_out), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
  );
  logic [23:0] rom [32];
  logic [23:0] rom_q = 0, p1 = 0, p2 = 0;
  assign tw_data = rom_q;
  assign mul_out = p2;
  int checks = 0, errors = 0;
  function automatic logic [23:0] cmul(input logic [23:0] a, input logic [23:0] b);
    int ar, ai, br, bi, pr, pi;
    ar = int'($signed(a[23:12])); ai = int'($signed(a[11:0]));
    br = int'($signed(b[23:12])); bi = int'($signed(b[11:0]));
    pr = (ar * br - ai * bi) >>> 10;
    pi = (ar * bi + ai * br) >>> 10;
    return {pr[11:0], pi[11:0]};
  endfunction
  function automatic logic [23:0] exp_tw(input int k, input logic iv);
    logic [23:0] t;
    logic [11:0] im;
    t = rom[k];
    im = t[11:0];
    if (iv) im = (im == 12'h800) ? 12'h7FF : 12'h000 - im;
    return {t[23:12], im};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(posedge clk) begin
    if (tw_rd_en) rom_q <= rom[tw_addr];
    p1 <= cmul(mul_c, mul_t);
    p2 <= p1;
  end
  logic [2:0] hist = 0;
  logic acc, prev_last = 0, inv_tb = 0;
  logic [23:0] prev_c, prev_t, e;
  logic [23:0] q[$];
  logic [23:0] cap [N];
  logic [4:0] addr_cap [N];
  int n_tb = 0, out_cnt = 0, done_cnt = 0, ea;
  always @(negedge clk)
    if (!reset) begin
      hist = 0;
      prev_last = 0;
      q.delete();
    end else begin
      acc = in_valid && in_ready;
      chk("tw_rd_en", tw_rd_en, acc);
      chk("out_valid", out_valid, hist[2]);
      chk("done", done, prev_last);
      if (hist[0]) begin
        chk("mul_c", mul_c, prev_c);
        chk("mul_t", mul_t, prev_t);
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_data: out_valid with no pending sample");
        end else begin
          e = q.pop_front();
          chk("out_data", out_data, e);
        end
        chk("out_last", out_last, out_cnt == N - 1);
        if (out_cnt < N) cap[out_cnt] = out_data;
        out_cnt++;
      end
      if (acc) begin
        ea = n_tb >= N / 2 ? n_tb - N / 2 : 0;
        chk("tw_addr", tw_addr, ea);
        if (n_tb < N) addr_cap[n_tb] = tw_addr;
        prev_c = in_data;
        prev_t = exp_tw(ea, inv_tb);
        q.push_back(cmul(in_data, prev_t));
        n_tb++;
      end
      prev_last = out_valid && out_cnt == N;
      if (done) done_cnt++;
      hist = {hist[1:0], acc};
    end
  task automatic begin_frame(input logic iv);
    in_valid = 1;
    in_data = 24'h123456;
    repeat (2) begin
      @(posedge clk); #1;
      chk("idle_in_ready", in_ready, 0);
      chk("idle_busy", busy, 0);
    end
    in_valid = 0;
    n_tb = 0; out_cnt = 0; done_cnt = 0; inv_tb = iv;
    start = 1; inv = iv;
    @(posedge clk); #1;
    start = 0; inv = ~iv;
    chk("run_busy", busy, 1);
    chk("run_in_ready", in_ready, 1);
  endtask
  task automatic run_frame(input logic iv, input logic [23:0] d, input bit gap, input bit poke);
    int cyc;
    begin_frame(iv);
    cyc = 0;
    while (n_tb < N && cyc < 400) begin
      in_valid = gap ? (cyc % 2 == 0) : 1'b1;
      in_data = d;
      start = poke && n_tb == 10;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 0; start = 0;
    chk("accepted", n_tb, N);
    cyc = 0;
    while (done_cnt == 0 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_seen", done_cnt, 1);
    chk("out_count", out_cnt, N);
    chk("post_busy", busy, 0);
    @(posedge clk); #1;
    chk("done_pulse", done, 0);
  endtask
  typedef struct {
    logic iv;
    logic [23:0] d;
    int n;
    bit gap;
    bit poke;
    logic [4:0] exp_addr;
    logic [23:0] exp_out;
  } vec_t;
  vec_t vt [8];
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rom[0] = {W_ONE, 12'sd0};
    for (int k = 1; k < 31; k++) rom[k] = {12'(1024 - 16 * k), 12'(-32 * k)};
    rom[31] = {12'd0, 12'h800};
    vt[0] = '{1'b0, 24'h400000, 5, 1'b0, 1'b0, 5'd0, 24'h400000};
    vt[1] = '{1'b0, 24'h400000, 40, 1'b0, 1'b0, 5'd8, 24'h380F00};
    vt[2] = '{1'b1, 24'h400000, 40, 1'b1, 1'b0, 5'd8, 24'h380100};
    vt[3] = '{1'b1, 24'h400000, 63, 1'b0, 1'b0, 5'd31, 24'h0007FF};
    vt[4] = '{1'b0, 24'h400000, 63, 1'b0, 1'b0, 5'd31, 24'h000800};
    vt[5] = '{1'b1, 24'h200E00, 0, 1'b0, 1'b0, 5'd0, 24'h200E00};
    vt[6] = '{1'b0, 24'h200000, 33, 1'b1, 1'b0, 5'd1, 24'h1F8FF0};
    vt[7] = '{1'b1, 24'h200000, 33, 1'b0, 1'b1, 5'd1, 24'h1F8010};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_tw_rd_en", tw_rd_en, 0);
    chk("rst_tw_addr", tw_addr, 0);
    chk("rst_mul_c", mul_c, 0);
    chk("rst_mul_t", mul_t, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1;
    @(posedge clk); #1;
    chk("rel_in_ready", in_ready, 0);
    chk("rel_busy", busy, 0);
    chk("rel_out_valid", out_valid, 0);
    for (int i = 0; i < 8; i++) begin
      run_frame(vt[i].iv, vt[i].d, vt[i].gap, vt[i].poke);
      chk($sformatf("vec%0d_addr", i), addr_cap[vt[i].n], vt[i].exp_addr);
      chk($sformatf("vec%0d_out", i), cap[vt[i].n], vt[i].exp_out);
    end
    begin_frame(1'b0);
    while (n_tb < 20) begin
      in_valid = 1;
      in_data = 24'h400000;
      @(posedge clk); #1;
    end
    in_valid = 0;
    reset = 0;
    @(posedge clk); #1;
    reset = 1;
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_out_valid", out_valid, 0);
    repeat (8) begin
      @(posedge clk); #1;
      chk("abort_no_out", out_valid, 0);
      chk("abort_no_done", done, 0);
    end
    run_frame(1'b0, 24'h400000, 1'b0, 1'b0);
    chk("after_abort_addr", addr_cap[50], 5'd18);
    chk("after_abort_out", cap[50], {12'(1024 - 16 * 18), 12'(-32 * 18)});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
